// File: rtl/decryption_pkg.sv
// Shared types for the decryption datapath.
// Used by the cipher stages, the packer and its FIFO.
package decryption_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ACC0,
    ACC1,
    ACC2,
    ACC3
  } acc_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [2:0]        bytes;
    logic              last;
  } fifo_entry_t;

endpackage

// File: rtl/decryption_packer_if.sv
// Byte-in / word-out bundle of the packer.
// master drives bytes and ready, slave is the packer.
interface decryption_packer_if;
  import decryption_pkg::*;

  logic [BYTE_W-1:0] data_i;
  logic              valid_i;
  logic              flush_i;
  logic              ready_i;
  logic [WORD_W-1:0] data_o;
  logic [2:0]        bytes_o;
  logic              last_o;
  logic              valid_o;
  logic              overflow_o;

  modport master (
    output data_i, valid_i, flush_i, ready_i,
    input  data_o, bytes_o, last_o,
    input  valid_o, overflow_o
  );

  modport slave (
    input  data_i, valid_i, flush_i, ready_i,
    output data_o, bytes_o, last_o,
    output valid_o, overflow_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO, power-of-two depth.
// Head reads as zero while empty; drops pushes when full.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_wen;

  assign w_empty = (r_wr == r_rd);
  assign w_full  = (r_wr[AW] != r_rd[AW]) &&
                   (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = !w_empty && i_ready;
  // A pop frees the slot the push lands in.
  assign w_wen   = i_push && (!w_full || w_pop);
  assign o_drop  = i_push && w_full && !w_pop;

  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];

  // Pointer update; pointers carry a wrap bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_wen) r_wr <= r_wr + (AW+1)'(1);
      if (w_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_wen) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/decryption_packer.sv
// Packs the plaintext byte stream into 32-bit words.
// MSB-first lanes, flush closes a message with a partial word.
module decryption_packer
  import decryption_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  decryption_packer_if.slave bus
);

  acc_state_t        r_state;
  logic [BYTE_W-1:0] r_lane [3];
  logic              r_overflow;

  logic [WORD_W-1:0] w_word;
  logic [2:0]        w_cnt;
  logic              w_push;
  logic              w_drop;
  fifo_entry_t       w_entry;
  fifo_entry_t       w_head;

  // Merge this cycle's byte, then decide whether a word leaves.
  always_comb begin
    w_cnt  = {1'b0, r_state};
    w_word = {r_lane[0], r_lane[1], r_lane[2],
              {BYTE_W{1'b0}}};
    if (bus.valid_i) begin
      w_cnt = w_cnt + 3'd1;
      unique case (r_state)
        ACC0: w_word[31:24] = bus.data_i;
        ACC1: w_word[23:16] = bus.data_i;
        ACC2: w_word[15:8]  = bus.data_i;
        ACC3: w_word[7:0]   = bus.data_i;
      endcase
    end
    w_push = (w_cnt == 3'd4) ||
             (bus.flush_i && w_cnt != 3'd0);
    w_entry.data  = w_word;
    w_entry.bytes = w_cnt;
    w_entry.last  = bus.flush_i;
  end

  // Accumulator FSM; lanes are cleared on every push
  // so unused low bytes of a partial word read as zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ACC0;
      r_lane[0]  <= '0;
      r_lane[1]  <= '0;
      r_lane[2]  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_state   <= ACC0;
        r_lane[0] <= '0;
        r_lane[1] <= '0;
        r_lane[2] <= '0;
      end else if (bus.valid_i) begin
        r_state <= acc_state_t'(r_state + 2'd1);
        case (r_state)
          ACC0:    r_lane[0] <= bus.data_i;
          ACC1:    r_lane[1] <= bus.data_i;
          ACC2:    r_lane[2] <= bus.data_i;
          default: ;
        endcase
      end
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_ready (bus.ready_i),
    .o_data  (w_head),
    .o_valid (bus.valid_o),
    .o_drop  (w_drop)
  );

  assign bus.data_o     = w_head.data;
  assign bus.bytes_o    = w_head.bytes;
  assign bus.last_o     = w_head.last;
  assign bus.overflow_o = r_overflow;

endmodule

// File: tb/tb_decryption_packer.sv
// Scoreboard bench for decryption_packer.
// Directed byte streams; monitor checks every head seen.
module tb_decryption_packer;
  import decryption_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decryption_packer_if bus();

  decryption_packer #(.FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fifo_entry_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [39:0] act,
                       input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // Monitor: compare the head against the scoreboard.
  always @(negedge clk) begin
    if (!rst && bus.valid_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %h/%0d/%0d",
                 bus.data_o, bus.bytes_o, bus.last_o);
      end else begin
        check(bus.ready_i ? "pop_word" : "held_word",
              {4'h0, bus.data_o, bus.bytes_o, bus.last_o},
              {4'h0, exp_q[0]});
        if (bus.ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic drv(input logic v, input logic [7:0] b,
                     input logic f, input logic r);
    @(posedge clk);
    #1;
    bus.valid_i = v;
    bus.data_i  = b;
    bus.flush_i = f;
    bus.ready_i = r;
  endtask

  task automatic expect_word(input logic [31:0] d,
                             input logic [2:0] n,
                             input logic l);
    fifo_entry_t e;
    e.data  = d;
    e.bytes = n;
    e.last  = l;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] w,
                           input logic r);
    drv(1'b1, w[31:24], 1'b0, r);
    drv(1'b1, w[23:16], 1'b0, r);
    drv(1'b1, w[15:8],  1'b0, r);
    drv(1'b1, w[7:0],   1'b0, r);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      drv(1'b0, 8'h00, 1'b0, 1'b1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d words left",
               exp_q.size());
      exp_q.delete();
    end
    repeat (3) drv(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic check_reset_outs(input string name);
    check(name,
          {2'b0, bus.valid_o, bus.data_o, bus.bytes_o,
           bus.last_o, bus.overflow_o},
          40'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    bus.flush_i = 1'b0;
    bus.ready_i = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset_outputs");
    rst = 1'b0;

    // Full word and one-cycle latency.
    expect_word(32'h41424344, 3'd4, 1'b0);
    drv(1'b1, 8'h41, 1'b0, 1'b1);
    drv(1'b1, 8'h42, 1'b0, 1'b1);
    drv(1'b1, 8'h43, 1'b0, 1'b1);
    drv(1'b1, 8'h44, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_before", {39'h0, bus.valid_o}, 40'h0);
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    check("lat_after", {39'h0, bus.valid_o}, 40'h1);
    drain();

    // Partial flush, then a flush in ACC0.
    expect_word(32'h51440000, 3'd2, 1'b1);
    drv(1'b1, 8'h51, 1'b0, 1'b1);
    drv(1'b1, 8'h44, 1'b0, 1'b1);
    drv(1'b0, 8'h00, 1'b1, 1'b1);
    drv(1'b0, 8'h00, 1'b0, 1'b1);
    drv(1'b0, 8'h00, 1'b1, 1'b1);
    drain();

    // Byte and flush together on the fourth byte.
    expect_word(32'h41424344, 3'd4, 1'b1);
    drv(1'b1, 8'h41, 1'b0, 1'b1);
    drv(1'b1, 8'h42, 1'b0, 1'b1);
    drv(1'b1, 8'h43, 1'b0, 1'b1);
    drv(1'b1, 8'h44, 1'b1, 1'b1);
    drain();

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      w = 32'h10111213 + 32'h04040404 * i;
      expect_word(w, 3'd4, 1'b0);
      send_word(w, 1'b0);
    end
    expect_word(32'h20212223, 3'd4, 1'b0);
    drv(1'b1, 8'h20, 1'b0, 1'b0);
    drv(1'b1, 8'h21, 1'b0, 1'b0);
    drv(1'b1, 8'h22, 1'b0, 1'b0);
    drv(1'b1, 8'h23, 1'b0, 1'b1);
    drain();
    check("pushpop_no_overflow",
          {39'h0, bus.overflow_o}, 40'h0);

    // Backpressure: fifth word is dropped.
    for (int i = 0; i < 5; i++) begin
      w = 32'h01020304 + 32'h04040404 * i;
      if (i < 4) expect_word(w, 3'd4, 1'b0);
      send_word(w, 1'b0);
    end
    repeat (3) drv(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("overflow_set", {39'h0, bus.overflow_o}, 40'h1);
    drain();
    check("overflow_sticky",
          {39'h0, bus.overflow_o}, 40'h1);

    // Reset mid-message overrides byte and flush.
    drv(1'b1, 8'hE1, 1'b0, 1'b1);
    drv(1'b1, 8'hE2, 1'b0, 1'b1);
    drv(1'b1, 8'hE3, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.valid_i = 1'b1;
    bus.data_i  = 8'hE4;
    bus.flush_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst_mid_1");
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst_mid_2");
    rst = 1'b0;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    expect_word(32'hAABBCCDD, 3'd4, 1'b0);
    send_word(32'hAABBCCDD, 1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
